// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master alternating-priority arbiter onto one shared slave bus.
// Define BUS_ARB_TIMEOUT_EN to abort grants that exceed TIMEOUT_CYCLES slave cycles.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_ren,
    input  logic        m0_wen,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_ren,
    input  logic        m1_wen,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wmask,
    output logic        s_ren,
    output logic        s_wen,
    input  logic [31:0] s_rdata,
    input  logic        s_done,
    output logic        err_timeout
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t      state, state_nx;
    logic        last_grant;
    logic        req0, req1, g0, g1, busy, abort, fin, other_req;
    logic [31:0] rdata;

    assign req0      = m0_ren | m0_wen;
    assign req1      = m1_ren | m1_wen;
    assign g0        = state == GRANT0;
    assign g1        = state == GRANT1;
    assign busy      = g0 | g1;
    assign fin       = busy & (s_done | abort);
    assign other_req = g0 ? req1 : req0;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int cw = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [cw-1:0] limit = cw'(TIMEOUT_CYCLES - 1);

    logic [cw-1:0] cnt;

    // Cleared whenever a grant starts, so each transaction gets the full budget
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (!busy || fin) ? '0 : cnt + 1'b1;
    end

    assign abort = busy & ~s_done & (cnt == limit);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign abort          = 1'b0;
`endif

    // A tie goes to whichever master was not served last
    always_comb begin
        state_nx = !busy ? ((req0 & req1) ? (last_grant ? GRANT0 : GRANT1) :
                            req0 ? GRANT0 : req1 ? GRANT1 : IDLE) :
                   fin   ? (other_req ? (g0 ? GRANT1 : GRANT0) : IDLE) :
                           state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nx;
            if (fin) last_grant <= g1;
        end
    end

    assign s_addr      = g0 ? m0_addr  : g1 ? m1_addr  : '0;
    assign s_wdata     = g0 ? m0_wdata : g1 ? m1_wdata : '0;
    assign s_wmask     = g0 ? m0_wmask : g1 ? m1_wmask : '0;
    assign s_ren       = g0 ? m0_ren   : g1 ? m1_ren   : 1'b0;
    assign s_wen       = g0 ? m0_wen   : g1 ? m1_wen   : 1'b0;
    assign rdata       = abort ? 32'hDEAD_BEEF : s_rdata;
    assign m0_done     = g0 & (s_done | abort);
    assign m1_done     = g1 & (s_done | abort);
    assign m0_rdata    = g0 ? rdata : '0;
    assign m1_rdata    = g1 ? rdata : '0;
    assign err_timeout = abort;
endmodule
